piso_tx_scheduler: RTL
======================

# piso_tx_scheduler

Round-robin scheduler that shares one 16-bit PISO serializer between NUM_REQ parallel-word requesters. It accepts one word at a time over a valid/ready handshake and drives the serializer's load_shift/pin controls through a load-then-16-shift sequence. It emits bit-valid/index framing for the downstream SIPO, and cross-checks the serializer's complete flag. It sits directly in front of the PISO in the PISO-to-SIPO link.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, word width; fixed to the serializer width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester word valid; held until accepted
- req_data  in  NUM_REQ*DATA_W  word of requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot accept pulse; word i is taken on the edge ending a cycle where valid[i] and ready[i] are both high
- halt  in  1  when high, no new grant; an in-flight frame completes
- piso_complete  in  1  serializer complete flag, used for cross-check only
- load_shift  out  1  serializer control: 1 = load pin, 0 = shift
- pin  out  DATA_W  serializer parallel word
- bit_valid  out  1  high in each cycle the serializer's sout carries a frame bit
- bit_idx  out  4  index of the current bit; 0 = MSB first
- grant_id  out  clog2(NUM_REQ)  requester that owns the current frame
- frame_done  out  1  one-cycle pulse in the last shift cycle
- busy  out  1  high in LOAD and SHIFT
- sync_err  out  1  sticky mismatch flag

## Operation
- States: IDLE, LOAD, SHIFT. Reset enters IDLE.
- IDLE:
  - load_shift=1, so the serializer keeps reloading and never shifts.
  - If halt=0 and any req_valid is set, the round-robin winner i gets req_ready[i]=1 in the same cycle (combinational from the registered state).
  - On that edge: capture req_data[i] into the word register, set grant_id=i and last_grant=i, then go to LOAD.
- Round robin:
  - The search starts at last_grant+1 and wraps modulo NUM_REQ.
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.
- LOAD (1 cycle): load_shift=1 and pin=captured word. Then go to SHIFT with bit_cnt=0.
- SHIFT (16 cycles):
  - Signals: load_shift=0, bit_valid=1, bit_idx=bit_cnt; bit_cnt increments each cycle.
  - The serializer's sout equals word[15-bit_idx].
  - At bit_cnt=15: frame_done=1. Arbitration runs exactly as in IDLE (same halt gating and same cycle's req_ready). A grant goes to LOAD; otherwise go to IDLE.
- pin holds the last captured word through SHIFT and IDLE. The serializer ignores it while shifting.
- Cross-check, evaluated only in SHIFT:
  - Required: piso_complete == (bit_cnt==15).
  - Any mismatch sets sync_err. It is cleared only by reset.
- Halt:
  - Raising halt mid-frame does not stop shifting.
  - In the bit 15 cycle, halt=1 suppresses the next grant, and the block goes to IDLE.
- Requester rules:
  - A requester that drops valid before ready is simply not granted; this is not an error.
  - Data is sampled only on the accept edge.

## Timing
- Reset values: load_shift=1, pin=0, req_ready=0, bit_valid=0, bit_idx=0, grant_id=0, frame_done=0, busy=0, sync_err=0; state=IDLE.
- The serializer shares this reset, so its internal counter is aligned with bit_cnt from reset.
- Accept in cycle T:
  - LOAD in T+1.
  - bit_valid in T+2..T+17, with bit_idx 0..15.
  - frame_done in T+17.
- Back-to-back: the next accept in T+17 gives its LOAD in T+18. Throughput is 17 cycles per word with no idle gap.
- Reset asserted mid-frame:
  - All outputs immediately take their reset values; the frame is abandoned.
  - There is no req_ready retry bookkeeping; the requester still holds valid.
- Only one req_ready bit is ever high, and never outside IDLE or the bit 15 cycle of SHIFT.

## Test plan
- Single word from requester 1 with data 0xA5C3 accepted at T:
  - LOAD with pin=0xA5C3 at T+1.
  - sout bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 with bit_idx 0..15 in T+2..T+17.
  - frame_done at T+17; back to IDLE with busy=0.
- All four requesters valid continuously from reset:
  - Grants in order 0,1,2,3,0, with accepts spaced exactly 17 cycles apart.
  - load_shift low for 16 of every 17 cycles.
- halt raised at bit_idx 7 with requests pending:
  - The frame completes and no req_ready is issued while halt=1.
  - Deasserting halt gives req_ready in that same cycle.
- Bench forces piso_complete=1 at bit_idx 4 → sync_err=1 from the next cycle and stays high until rst low.
- rst pulled low at bit_idx 9:
  - All outputs at reset values asynchronously.
  - After release with requester 2 still valid, requester 0 is not valid, so requester 2 is granted; grant_id=2.
- Requester 3 drops valid in the same cycle that requester 1 is granted → no grant to 3. The word captured is req_data[1].

Source files
------------

// File: rtl/piso_tx_scheduler.sv
// Round-robin front end for a shared 16-bit PISO serializer: accepts one word
// per frame from NUM_REQ requesters, sequences load-then-16-shift, and emits
// bit framing plus a complete-flag cross-check for the downstream SIPO.
module piso_tx_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        halt,
  input  logic                        piso_complete,
  output logic                        load_shift,
  output logic [DATA_W-1:0]           pin,
  output logic                        bit_valid,
  output logic [3:0]                  bit_idx,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        sync_err
);

  localparam int unsigned GRANT_W  = $clog2(NUM_REQ);
  localparam int unsigned IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] PENU_BIT = IDX_W'(DATA_W - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  state_t               r_state;
  logic [GRANT_W-1:0]   r_last_grant;
  logic [GRANT_W-1:0]   r_grant_id;
  logic [DATA_W-1:0]    r_pin;
  logic [IDX_W-1:0]     r_bit_cnt;
  logic                 r_load_shift;
  logic                 r_bit_valid;
  logic                 r_frame_done;
  logic                 r_busy;
  logic                 r_sync_err;

  logic                 w_arb_en;
  logic                 w_found;
  logic                 w_grant;
  logic [GRANT_W-1:0]   w_cand;
  logic [GRANT_W-1:0]   w_win;
  logic [DATA_W-1:0]    w_word;
  logic [NUM_REQ-1:0]   w_ready;

  // Round-robin search starting after the last grant; enabled only in IDLE
  // or the final shift cycle, and forced off while reset is asserted.
  always_comb begin
    w_arb_en = rst && !halt &&
               ((r_state == ST_IDLE) ||
                ((r_state == ST_SHIFT) && (r_bit_cnt == LAST_BIT)));
    w_found  = 1'b0;
    w_cand   = '0;
    w_win    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = GRANT_W'((32'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
    w_grant = w_arb_en && w_found;
  end

  // Winner's data mux and one-hot accept pulse.
  always_comb begin
    w_word  = '0;
    w_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win == GRANT_W'(i)) begin
        w_word     = req_data[i*DATA_W +: DATA_W];
        w_ready[i] = w_grant;
      end
    end
  end

  assign req_ready  = w_ready;
  assign load_shift = r_load_shift;
  assign pin        = r_pin;
  assign bit_valid  = r_bit_valid;
  assign bit_idx    = r_bit_cnt;
  assign grant_id   = r_grant_id;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign sync_err   = r_sync_err;

  // Frame sequencer: state plus registered serializer controls and framing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_pin        <= '0;
      r_bit_cnt    <= '0;
      r_load_shift <= 1'b1;
      r_bit_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state      <= ST_LOAD;
            r_pin        <= w_word;
            r_grant_id   <= w_win;
            r_last_grant <= w_win;
            r_busy       <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state      <= ST_SHIFT;
          r_load_shift <= 1'b0;
          r_bit_valid  <= 1'b1;
          r_bit_cnt    <= '0;
          r_frame_done <= 1'b0;
        end
        ST_SHIFT: begin
          // Serializer must flag complete exactly on the last bit.
          if (piso_complete != (r_bit_cnt == LAST_BIT)) begin
            r_sync_err <= 1'b1;
          end
          if (r_bit_cnt != LAST_BIT) begin
            r_bit_cnt    <= r_bit_cnt + IDX_W'(1);
            r_frame_done <= (r_bit_cnt == PENU_BIT);
          end else begin
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_load_shift <= 1'b1;
            if (w_grant) begin
              r_state      <= ST_LOAD;
              r_pin        <= w_word;
              r_grant_id   <= w_win;
              r_last_grant <= w_win;
              r_busy       <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_load_shift <= 1'b1;
          r_bit_valid  <= 1'b0;
          r_bit_cnt    <= '0;
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
